fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATASIZE, default 8: data word width, equal to the FIFO data width.
REQ-002 SHALL have parameter CNTSIZE, default 16: width of the transfer counter.
REQ-003 SHALL have port rclk, input, 1: single clock, the FIFO read clock; all state on its rising edge.
REQ-004 SHALL have port rrst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port rempty, input, 1: FIFO empty flag, synchronous to rclk.
REQ-006 SHALL have port rdata, input, DATASIZE: FIFO head word, first-word-fall-through, valid whenever rempty=0.
REQ-007 SHALL have port rinc, output, 1: FIFO pop strobe.
REQ-008 SHALL have port en, input, 1: pop enable; the buffer still drains while en=0.
REQ-009 SHALL have port flush, input, 1: synchronous discard of buffered words.
REQ-010 SHALL have port m_valid, output, 1: output word valid.
REQ-011 SHALL have port m_ready, input, 1: downstream ready.
REQ-012 SHALL have port m_data, output, DATASIZE: output word.
REQ-013 SHALL have port occ, output, 2: buffer occupancy, 0..2.
REQ-014 SHALL have port xfer_cnt, output, CNTSIZE: count of completed output handshakes.

Function
REQ-015 SHALL hold a 2-entry ordered buffer: slot0 is the head and slot1 is the skid entry.
REQ-016 SHALL drive rinc combinationally as en & ~flush & ~rempty & (occ<2) & ~rrst; rinc SHALL NOT depend on m_ready.
REQ-017 SHALL never assert rinc while rempty=1.
REQ-018 SHALL define pop = rinc, sampled at a rising edge, and capture rdata into the buffer at that edge.
REQ-019 SHALL define hs = m_valid & m_ready at a rising edge.
REQ-020 SHALL drive m_valid = (occ != 0) and m_data = slot0, both from registers only.
REQ-021 SHALL place a popped word as follows:
- occ=0: into slot0.
- occ=1 and hs=0: into slot1.
- occ=1 and hs=1: into slot0.
REQ-022 SHALL, on hs with occ=2, move slot1 into slot0.
REQ-023 SHALL update occ_next = occ + pop - hs; occ SHALL never exceed 2 or underflow.
REQ-024 SHALL give a latency of 1 cycle: a word popped at edge N appears on m_data with m_valid=1 after edge N when the buffer was empty.
REQ-025 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-026 SHALL deliver words in FIFO order with no loss or duplication, other than by flush.
REQ-027 SHALL sustain 1 word/cycle when rempty=0, en=1 and m_ready=1 continuously.
REQ-028 SHALL, with flush=1 at an edge, set occ to 0 and suppress pop; a handshake on that edge SHALL still count in xfer_cnt.
REQ-029 SHALL increment xfer_cnt by 1 on every hs, wrapping modulo 2^CNTSIZE.
REQ-030 SHALL, when en falls, take no new pops while remaining words still drain via handshakes.

Reset
REQ-031 SHALL, while rrst=1, asynchronously clear occ, slot0, slot1 and xfer_cnt to 0, giving m_valid=0, m_data=0 and rinc=0.
REQ-032 SHALL resume normal operation at the first rising edge after rrst deasserts, with no pop on that same edge unless the REQ-016 conditions hold.
REQ-033 SHALL, when rrst asserts mid-operation, discard buffered words; words already popped from the FIFO are lost by design.

Verification
REQ-034 SHALL cover reset then single word: FIFO holds 0xA5, en=1, m_ready=1 -> rinc pulses 1 cycle; next cycle m_valid=1, m_data=0xA5; xfer_cnt=1.
REQ-035 SHALL cover streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> 16 consecutive valid cycles with data 0x01..0x10 in order; xfer_cnt=16; rinc never high with rempty=1.
REQ-036 SHALL cover backpressure: words 0x11,0x22,0x33 queued, m_ready=0 -> occ reaches 2, rinc drops, m_data holds 0x11; m_ready=1 -> outputs 0x11,0x22,0x33 without gaps.
REQ-037 SHALL cover flush: occ=2 holding 0x44,0x55 and flush pulsed with m_ready=0 -> occ=0, m_valid=0 next cycle; next delivered word is the FIFO head 0x66.
REQ-038 SHALL cover wrap and reset: CNTSIZE=4 with 17 transfers -> xfer_cnt=1; then rrst asserted mid-stream -> all outputs 0 immediately, independent of rclk.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops words from a first-word-fall-through FIFO into a
// 2-entry skid buffer and presents them on a valid/ready output stream,
// counting completed output handshakes.
module fifo_rd_stream #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned CNTSIZE  = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  input  logic                en,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic [1:0]          occ,
  output logic [CNTSIZE-1:0]  xfer_cnt
);

  localparam int unsigned OCCW = 2;

  logic [OCCW-1:0]     occ_q, occ_d;
  logic [DATASIZE-1:0] slot0_q, slot0_d;
  logic [DATASIZE-1:0] slot1_q, slot1_d;
  logic [CNTSIZE-1:0]  cnt_q, cnt_d;
  logic                pop;
  logic                hs;

  // Pop strobe: only when there is room, never on empty, independent of m_ready.
  assign rinc = en & ~flush & ~rempty & (occ_q < OCCW'(2)) & ~rrst;
  assign pop  = rinc;

  // Outputs come straight from the buffer registers.
  assign m_valid  = (occ_q != OCCW'(0));
  assign m_data   = slot0_q;
  assign occ      = occ_q;
  assign xfer_cnt = cnt_q;
  assign hs       = m_valid & m_ready;

  // Buffer placement, skid promotion, flush and handshake counting.
  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;

    if (hs) begin
      cnt_d = cnt_q + CNTSIZE'(1);
    end

    if (flush) begin
      occ_d = OCCW'(0);
    end else begin
      unique case (occ_q)
        OCCW'(0): begin
          if (pop) begin
            slot0_d = rdata;
            occ_d   = OCCW'(1);
          end
        end
        OCCW'(1): begin
          if (pop && hs) begin
            slot0_d = rdata;
          end else if (pop) begin
            slot1_d = rdata;
            occ_d   = OCCW'(2);
          end else if (hs) begin
            occ_d   = OCCW'(0);
          end
        end
        OCCW'(2): begin
          // rinc is gated off when full, so only a handshake can move data.
          if (hs) begin
            slot0_d = slot1_q;
            occ_d   = OCCW'(1);
          end
        end
        default: begin
          occ_d = OCCW'(0);
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ_q   <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and output-buffer model,
// directed scenarios plus randomized traffic. A second instance with a
// 4-bit counter exercises counter wrap on the same stimulus.
module tb_fifo_rd_stream;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWW = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          en;
  logic          flush;
  logic          m_ready;

  logic          rinc, rinc_w;
  logic          m_valid, m_valid_w;
  logic [DW-1:0] m_data, m_data_w;
  logic [1:0]    occ, occ_w;
  logic [CW-1:0] xfer_cnt;
  logic [CWW-1:0] xfer_cnt_w;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] buf_q[$];
  int unsigned   exp_cnt;
  int            checks;
  int            errors;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATASIZE(DW), .CNTSIZE(CW)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .en(en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occ(occ), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DATASIZE(DW), .CNTSIZE(CWW)) dut_w (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_w),
    .en(en), .flush(flush), .m_valid(m_valid_w), .m_ready(m_ready),
    .m_data(m_data_w), .occ(occ_w), .xfer_cnt(xfer_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present the modelled FIFO head to both DUTs.
  task automatic drive_fifo();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? DW'(8'hEE) : fifo_q[0];
  endtask

  // One clock cycle: compare against the model, clock, then advance the model.
  task automatic tick();
    bit exp_pop;
    bit exp_hs;
    drive_fifo();
    #1;
    exp_pop = en && !flush && !rrst && (fifo_q.size() != 0) && (buf_q.size() < 2);
    exp_hs  = (buf_q.size() != 0) && m_ready;
    check("rinc", 32'(rinc), 32'(exp_pop));
    check("rinc_w", 32'(rinc_w), 32'(exp_pop));
    check("rinc_on_empty", 32'(rinc & rempty), 32'd0);
    check("m_valid", 32'(m_valid), 32'(buf_q.size() != 0));
    check("occ", 32'(occ), 32'(buf_q.size()));
    if (buf_q.size() != 0) check("m_data", 32'(m_data), 32'(buf_q[0]));
    check("xfer_cnt", 32'(xfer_cnt), exp_cnt % 32'd65536);
    check("xfer_cnt_w", 32'(xfer_cnt_w), exp_cnt % 32'd16);
    @(posedge rclk);
    if (exp_hs) exp_cnt++;
    if (flush) begin
      buf_q.delete();
    end else begin
      if (exp_hs) void'(buf_q.pop_front());
      if (exp_pop) buf_q.push_back(fifo_q[0]);
    end
    if (exp_pop) void'(fifo_q.pop_front());
    @(negedge rclk);
  endtask

  // Assert reset between clock edges and confirm outputs clear immediately.
  task automatic async_reset(input string tag);
    #2;
    rrst = 1'b1;
    #1;
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_occ"}, 32'(occ), 32'd0);
    check({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'd0);
    check({tag, "_xfer_cnt_w"}, 32'(xfer_cnt_w), 32'd0);
    check({tag, "_rinc"}, 32'(rinc), 32'd0);
    buf_q.delete();
    exp_cnt = 0;
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rrst    = 1'b1;
    en      = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b1;
    fifo_q.push_back(DW'(8'hA5));
    drive_fifo();
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    repeat (2) @(negedge rclk);
    rrst = 1'b0;

    // Single word after reset.
    tick();
    check("single_valid", 32'(m_valid), 32'd1);
    check("single_data", 32'(m_data), 32'hA5);
    tick();
    check("single_cnt", 32'(xfer_cnt), 32'd1);
    check("single_empty", 32'(m_valid), 32'd0);

    // Streaming 0x01..0x10 at full rate.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(i));
    repeat (18) tick();
    check("stream_cnt", 32'(xfer_cnt), 32'd17);

    // Backpressure: fill the skid entry, then release.
    m_ready = 1'b0;
    fifo_q.push_back(DW'(8'h11));
    fifo_q.push_back(DW'(8'h22));
    fifo_q.push_back(DW'(8'h33));
    repeat (3) tick();
    drive_fifo();
    #1;
    check("bp_occ", 32'(occ), 32'd2);
    check("bp_hold", 32'(m_data), 32'h11);
    check("bp_rinc", 32'(rinc), 32'd0);
    @(negedge rclk);
    m_ready = 1'b1;
    repeat (5) tick();

    // Flush with two buffered words; 0x66 must come next.
    m_ready = 1'b0;
    fifo_q.push_back(DW'(8'h44));
    fifo_q.push_back(DW'(8'h55));
    fifo_q.push_back(DW'(8'h66));
    repeat (2) tick();
    check("fl_occ_full", 32'(occ), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_occ", 32'(occ), 32'd0);
    check("fl_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    tick();
    check("fl_next", 32'(m_data), 32'h66);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
      tick();
    end
    en = 1'b1;
    m_ready = 1'b1;
    flush = 1'b0;
    repeat (12) tick();

    // Counter wrap on the 4-bit instance.
    async_reset("rst_a");
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'(8'h80 + i));
    repeat (19) tick();
    check("wrap_cnt_w", 32'(xfer_cnt_w), 32'd1);
    check("wrap_cnt", 32'(xfer_cnt), 32'd17);

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(8'hC0 + i));
    m_ready = 1'b0;
    repeat (3) tick();
    async_reset("rst_mid");
    m_ready = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
